// File: rtl/dmrs_seq_ctrl.sv
// DMRS sequence job controller: validates a job, fetches the prime from ROM,
// then drives the Zadoff-Chu generator through nsym symbols with group hopping.
module dmrs_seq_ctrl #(
    parameter int unsigned MAX_SYM = 4,
    parameter int unsigned MAX_MZC = 792
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [9:0]  cfg_mzc,
    input  logic [4:0]  cfg_u0,
    input  logic [4:0]  cfg_hop,
    input  logic        cfg_v,
    input  logic [2:0]  cfg_nsym,
    output logic        rom_rd,
    output logic [9:0]  rom_addr,
    input  logic [9:0]  rom_prime,
    input  logic [29:0] rom_prime_rec,
    output logic        gen_enable,
    output logic [9:0]  gen_mzc,
    output logic [4:0]  gen_u,
    output logic        gen_v,
    output logic [9:0]  gen_prime,
    output logic [29:0] gen_prime_rec,
    input  logic [9:0]  gen_counter,
    input  logic        gen_valid,
    output logic [2:0]  sym_idx,
    output logic        busy,
    output logic        sym_done,
    output logic        job_done,
    output logic        cfg_err
);

    typedef enum logic [2:0] {StIdle, StLookup, StLoad, StGen, StGap} state_t;

    state_t      state_q, state_d;
    logic [2:0]  nsym_q;
    logic [4:0]  hop_q;

    logic        gen_enable_d, sym_done_d, job_done_d, cfg_err_d;
    logic [2:0]  sym_idx_d;
    logic [4:0]  gen_u_d;
    logic        load_cfg, load_prime;
    logic        mzc_ok, nsym_ok, cfg_ok, need_rom, last_sym;
    logic [5:0]  u_sum;
    logic [5:0]  u_wrap;

    // Generator validity is a generator-side concern; it is observed but never acted on.
    logic unused_gen_valid;
    assign unused_gen_valid = gen_valid;

    assign mzc_ok   = (cfg_mzc != 10'd0) && (cfg_mzc % 10'd6 == 10'd0)
                      && (32'(cfg_mzc) <= MAX_MZC);
    assign nsym_ok  = (cfg_nsym != 3'd0) && (32'(cfg_nsym) <= MAX_SYM);
    assign cfg_ok   = mzc_ok && nsym_ok && (cfg_u0 < 5'd30) && (cfg_hop < 5'd30);
    assign need_rom = (gen_mzc >= 10'd36);
    assign last_sym = (sym_idx == nsym_q - 3'd1);

    // Both operands are < 30, so a single conditional subtract keeps u in 0..29.
    assign u_sum  = {1'b0, gen_u} + {1'b0, hop_q};
    assign u_wrap = (u_sum >= 6'd30) ? (u_sum - 6'd30) : u_sum;

    assign rom_rd   = (state_q == StLookup) && need_rom;
    assign rom_addr = gen_mzc;
    assign busy     = (state_q != StIdle);

    always_comb begin
        state_d      = state_q;
        gen_enable_d = 1'b0;
        sym_done_d   = 1'b0;
        job_done_d   = 1'b0;
        cfg_err_d    = 1'b0;
        sym_idx_d    = sym_idx;
        gen_u_d      = gen_u;
        load_cfg     = 1'b0;
        load_prime   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A simultaneous abort suppresses the request entirely.
                if (start && !abort) begin
                    if (cfg_ok) begin
                        state_d   = StLookup;
                        load_cfg  = 1'b1;
                        gen_u_d   = cfg_u0;
                        sym_idx_d = 3'd0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StLookup: state_d = StLoad;
            StLoad: begin
                state_d      = StGen;
                load_prime   = 1'b1;
                gen_enable_d = 1'b1;
            end
            StGen: begin
                if (gen_enable && (gen_counter == gen_mzc)) begin
                    state_d    = StGap;
                    sym_done_d = 1'b1;
                    job_done_d = last_sym;
                    gen_u_d    = u_wrap[4:0];
                end else begin
                    gen_enable_d = 1'b1;
                end
            end
            StGap: begin
                if (last_sym) begin
                    state_d   = StIdle;
                    sym_idx_d = 3'd0;
                end else begin
                    state_d      = StGen;
                    sym_idx_d    = sym_idx + 3'd1;
                    gen_enable_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (abort && (state_q != StIdle)) begin
            state_d      = StIdle;
            gen_enable_d = 1'b0;
            sym_done_d   = 1'b0;
            job_done_d   = 1'b0;
            sym_idx_d    = 3'd0;
            load_prime   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            gen_enable    <= 1'b0;
            sym_done      <= 1'b0;
            job_done      <= 1'b0;
            cfg_err       <= 1'b0;
            sym_idx       <= 3'd0;
            gen_mzc       <= 10'd0;
            gen_u         <= 5'd0;
            gen_v         <= 1'b0;
            gen_prime     <= 10'd0;
            gen_prime_rec <= 30'd0;
            nsym_q        <= 3'd0;
            hop_q         <= 5'd0;
        end else begin
            state_q    <= state_d;
            gen_enable <= gen_enable_d;
            sym_done   <= sym_done_d;
            job_done   <= job_done_d;
            cfg_err    <= cfg_err_d;
            sym_idx    <= sym_idx_d;
            gen_u      <= gen_u_d;
            if (load_cfg) begin
                gen_mzc <= cfg_mzc;
                gen_v   <= cfg_v;
                nsym_q  <= cfg_nsym;
                hop_q   <= cfg_hop;
            end
            // Short sequences (Mzc < 36) are table-based and carry no prime.
            if (load_prime) begin
                gen_prime     <= need_rom ? rom_prime : 10'd0;
                gen_prime_rec <= need_rom ? rom_prime_rec : 30'd0;
            end
        end
    end

endmodule
